fir_mac_accumulator: RTL and testbench

FIR_MAC_ACCUMULATOR -- requirements
Module: fir_mac_accumulator

---
 rtl/fir_mac_accumulator.sv | 144 ++++++++++++++
 tb/tb_fir_mac_accumulator.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_mac_accumulator: two-stage MAC that sums 64 tap products per frame,  |
// | rounds half-up and saturates to Q1.15, with tap-sequence error checking. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_mac_accumulator #(
  parameter int NUM_TAPS = 64,
  parameter int ACC_W    = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  current_count,
  input  logic        phase_63,
  input  logic [15:0] input_mux,
  input  logic [15:0] coeff,
  output logic [15:0] o_filtered,
  output logic        o_valid,
  output logic        o_sat,
  output logic        o_seq_err
);

  localparam logic [5:0]              c_LAST_TAP = 6'(NUM_TAPS - 1);
  localparam logic signed [ACC_W-1:0] c_HALF     = ACC_W'(16384);
  localparam logic signed [ACC_W-1:0] c_POS_MAX  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] c_NEG_MIN  = ACC_W'(-32768);
  localparam logic [0:0]              c_ST_IDLE  = 1'b0;
  localparam logic [0:0]              c_ST_RUN   = 1'b1;

  logic signed [31:0]      r_prod;
  logic [5:0]              r_cnt_d;
  logic                    r_ph_d;
  logic                    r_vld_d;
  logic signed [ACC_W-1:0] r_acc;
  logic [5:0]              r_prev_cnt;
  logic [0:0]              r_state;
  logic [0:0]              w_state_next;

  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shifted;
  logic [5:0]              w_prev_inc;
  logic                    w_ph_err;
  logic                    w_cnt_err;
  logic                    w_seq_err;
  logic                    w_fire;
  logic                    w_clamped;
  logic [15:0]             w_result;

  // r_vld_d keeps the reset-cleared stage-1 contents from looking like tap 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod  <= '0;
      r_cnt_d <= '0;
      r_ph_d  <= 1'b0;
      r_vld_d <= 1'b0;
    end else begin
      r_prod  <= $signed(input_mux) * $signed(coeff);
      r_cnt_d <= current_count;
      r_ph_d  <= phase_63;
      r_vld_d <= 1'b1;
    end
  end

  assign w_prod_ext = {{(ACC_W-32){r_prod[31]}}, r_prod};
  assign w_sum      = (r_cnt_d == 6'd0) ? w_prod_ext : (r_acc + w_prod_ext);
  assign w_shifted  = (w_sum + c_HALF) >>> 15;
  assign w_prev_inc = r_prev_cnt + 6'd1;

  assign w_ph_err  = r_vld_d && (r_ph_d != (r_cnt_d == c_LAST_TAP));
  assign w_cnt_err = r_vld_d && (r_state == c_ST_RUN) &&
                     ((r_cnt_d == 6'd0) ? (r_prev_cnt != c_LAST_TAP)
                                        : (r_cnt_d != w_prev_inc));
  assign w_seq_err = w_ph_err || w_cnt_err;

  always_comb begin
    w_clamped = 1'b0;
    w_result  = w_shifted[15:0];
    if (w_shifted > c_POS_MAX) begin
      w_clamped = 1'b1;
      w_result  = 16'h7FFF;
    end else if (w_shifted < c_NEG_MIN) begin
      w_clamped = 1'b1;
      w_result  = 16'h8000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A well-phased tap 0 always (re)starts a frame, even when it also flags an error.
  always_comb begin
    w_state_next = r_state;
    if (r_vld_d) begin
      if (w_ph_err) begin
        w_state_next = c_ST_IDLE;
      end else if (r_cnt_d == 6'd0) begin
        w_state_next = c_ST_RUN;
      end else if (w_cnt_err) begin
        w_state_next = c_ST_IDLE;
      end
    end
  end

  always_comb begin
    w_fire = 1'b0;
    if (r_vld_d && (r_state == c_ST_RUN) && (r_cnt_d == c_LAST_TAP) && !w_seq_err) begin
      w_fire = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_prev_cnt <= '0;
    end else if (r_vld_d) begin
      r_acc      <= w_sum;
      r_prev_cnt <= r_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_filtered <= '0;
      o_valid    <= 1'b0;
      o_sat      <= 1'b0;
      o_seq_err  <= 1'b0;
    end else begin
      o_valid   <= w_fire;
      o_sat     <= w_fire && w_clamped;
      o_seq_err <= w_seq_err;
      if (w_fire) begin
        o_filtered <= w_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_accumulator.sv
`default_nettype none
// Testbench for fir_mac_accumulator: directed and random frames checked against
// a frame-level arithmetic model of the filter output stream.
module tb_fir_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  current_count;
  logic        phase_63;
  logic [15:0] input_mux;
  logic [15:0] coeff;
  logic [15:0] o_filtered;
  logic        o_valid;
  logic        o_sat;
  logic        o_seq_err;

  fir_mac_accumulator #(.NUM_TAPS(64), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .current_count(current_count), .phase_63(phase_63),
    .input_mux(input_mux), .coeff(coeff), .o_filtered(o_filtered),
    .o_valid(o_valid), .o_sat(o_sat), .o_seq_err(o_seq_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [18:0] obs;
  logic [18:0] expv;
  bit          have;
  logic [15:0] xs [64];
  logic [15:0] cs [64];

  // Reference model: per presented sample, the {valid,sat,seq_err,filtered}
  // expected two cycles later.
  bit          m_started;
  int          m_prev;
  longint      m_sum;
  logic [15:0] m_filt;
  logic [18:0] exp_q [$];

  function automatic void model_reset();
    exp_q.delete();
    m_started = 1'b0;
    m_prev    = 0;
    m_sum     = 0;
    m_filt    = 16'h0000;
  endfunction

  function automatic void model_push(input int cnt, input bit ph, input logic [15:0] x, input logic [15:0] c);
    longint p;
    longint r;
    bit     ph_err, serr, valid, sat;
    p      = longint'($signed(x)) * longint'($signed(c));
    ph_err = (ph != (cnt == 63));
    serr   = ph_err || (m_started && ((cnt == 0) ? (m_prev != 63) : (cnt != (m_prev + 1) % 64)));
    if (cnt == 0) m_sum = p;
    else          m_sum = m_sum + p;
    valid = (cnt == 63) && m_started && !serr;
    sat   = 1'b0;
    if (valid) begin
      r = (m_sum + 16384) >>> 15;
      if (r > 32767) begin r = 32767; sat = 1'b1; end
      else if (r < -32768) begin r = -32768; sat = 1'b1; end
      m_filt = 16'(r);
    end
    if (cnt == 0 && !ph_err) m_started = 1'b1;
    else if (serr)           m_started = 1'b0;
    m_prev = cnt;
    exp_q.push_back({valid, sat, serr, m_filt});
  endfunction

  // Called at a falling edge: samples outputs, presents one tap, advances one cycle.
  task automatic step(input int cnt, input bit ph, input logic [15:0] x, input logic [15:0] c);
    have = (exp_q.size() >= 2);
    obs  = {o_valid, o_sat, o_seq_err, o_filtered};
    expv = have ? exp_q.pop_front() : 19'h0;
    current_count = 6'(cnt);
    phase_63      = ph;
    input_mux     = x;
    coeff         = c;
    model_push(cnt, ph, x, c);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    current_count = 6'd0; phase_63 = 1'b0; input_mux = 16'h0; coeff = 16'h0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic gen_frame(input bit big);
    logic [15:0] t;
    for (int k = 0; k < 64; k++) begin
      xs[k] = 16'($urandom);
      t     = 16'($urandom);
      cs[k] = big ? t : {{4{t[15]}}, t[15:4]};
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 64; k++) begin
      xs[k] = 16'h0;
      cs[k] = 16'h0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    current_count = 6'd0; phase_63 = 1'b0; input_mux = 16'h0; coeff = 16'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o_valid, o_sat, o_seq_err, o_filtered} !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_state got {v,s,e,filt}=%h required 00000", {o_valid, o_sat, o_seq_err, o_filtered});
    end
    do_reset();
  endtask

  task automatic test_impulse();
    clear_frame();
    xs[0] = 16'h7FFF; cs[0] = 16'h4000;
    for (int k = 0; k < 66; k++) begin
      if (k < 64) step(k, k == 63, xs[k], cs[k]);
      else        step(k - 64, 1'b0, 16'h0, 16'h0);
      if (have) begin
        n_checks++;
        if (obs !== expv) begin
          n_errors++;
          $display("FAIL impulse step %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
        end
      end
    end
    n_checks++;
    if (obs[18] !== 1'b1 || obs[17] !== 1'b0 || obs[15:0] !== 16'h4000) begin
      n_errors++;
      $display("FAIL impulse_value got v=%b s=%b filt=%h required v=1 s=0 filt=4000", obs[18], obs[17], obs[15:0]);
    end
    do_reset();
  endtask

  task automatic test_rounding();
    clear_frame();
    xs[5] = 16'hFFFF; cs[5] = 16'h4000;
    for (int k = 0; k < 66; k++) begin
      if (k < 64) step(k, k == 63, xs[k], cs[k]);
      else        step(k - 64, 1'b0, 16'h0, 16'h0);
      if (have) begin
        n_checks++;
        if (obs !== expv) begin
          n_errors++;
          $display("FAIL rounding step %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
        end
      end
    end
    n_checks++;
    if (obs[18] !== 1'b1 || obs[17] !== 1'b0 || obs[15:0] !== 16'h0000) begin
      n_errors++;
      $display("FAIL rounding_value got v=%b s=%b filt=%h required v=1 s=0 filt=0000", obs[18], obs[17], obs[15:0]);
    end
    do_reset();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 130; k++) begin
      if (k < 64)       step(k, k == 63, 16'h7FFF, 16'h7FFF);
      else if (k < 128) step(k - 64, (k - 64) == 63, 16'h8000, 16'h7FFF);
      else              step(k - 128, 1'b0, 16'h0, 16'h0);
      if (have) begin
        n_checks++;
        if (obs !== expv) begin
          n_errors++;
          $display("FAIL saturation step %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
        end
      end
      if (k == 65) begin
        n_checks++;
        if (obs[18:17] !== 2'b11 || obs[15:0] !== 16'h7FFF) begin
          n_errors++;
          $display("FAIL sat_positive got v=%b s=%b filt=%h required v=1 s=1 filt=7fff", obs[18], obs[17], obs[15:0]);
        end
      end
    end
    n_checks++;
    if (obs[18:17] !== 2'b11 || obs[15:0] !== 16'h8000) begin
      n_errors++;
      $display("FAIL sat_negative got v=%b s=%b filt=%h required v=1 s=1 filt=8000", obs[18], obs[17], obs[15:0]);
    end
    do_reset();
  endtask

  task automatic test_seq_skip();
    int nv, ne, cnt;
    nv = 0; ne = 0;
    gen_frame(1'b0);
    for (int k = 0; k < 129; k++) begin
      if (k < 63)       begin cnt = (k < 11) ? k : k + 1; step(cnt, cnt == 63, xs[cnt], cs[cnt]); end
      else if (k < 127) step(k - 63, (k - 63) == 63, cs[k - 63], xs[k - 63]);
      else              step(k - 127, 1'b0, 16'h0, 16'h0);
      if (have) begin
        n_checks++;
        if (obs !== expv) begin
          n_errors++;
          $display("FAIL seq_skip step %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
        end
        if (obs[18]) nv++;
        if (obs[16]) ne++;
        if (k == 13) begin
          n_checks++;
          if (obs[16] !== 1'b1) begin
            n_errors++;
            $display("FAIL seq_skip_pulse got seq_err=%b required 1", obs[16]);
          end
        end
      end
    end
    n_checks++;
    if (nv != 1 || ne != 1 || obs[18] !== 1'b1) begin
      n_errors++;
      $display("FAIL seq_skip_counts got valids=%0d errs=%0d last_v=%b required 1 1 1", nv, ne, obs[18]);
    end
    do_reset();
  endtask

  task automatic test_phase_err();
    int ne;
    bit ph;
    ne = 0;
    for (int f = 0; f < 3; f++) begin
      gen_frame(1'b0);
      for (int k = 0; k < 64; k++) begin
        ph = (k == 63);
        if (f == 0 && k == 20) ph = 1'b1;
        if (f == 1 && k == 63) ph = 1'b0;
        step(k, ph, xs[k], cs[k]);
        if (have) begin
          n_checks++;
          if (obs !== expv) begin
            n_errors++;
            $display("FAIL phase_err frame %0d step %0d got {v,s,e,filt}=%h required %h", f, k, obs, expv);
          end
          if (obs[16]) ne++;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(k, 1'b0, 16'h0, 16'h0);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL phase_err flush %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
      end
    end
    n_checks++;
    if (ne != 2 || obs[18] !== 1'b1) begin
      n_errors++;
      $display("FAIL phase_err_counts got errs=%0d last_v=%b required 2 1", ne, obs[18]);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int nv;
    nv = 0;
    gen_frame(1'b0);
    for (int k = 0; k < 94; k++) begin
      step(k % 64, (k % 64) == 63, xs[k % 64], cs[k % 64]);
      if (have) begin
        n_checks++;
        if (obs !== expv) begin
          n_errors++;
          $display("FAIL reset_mid pre step %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
        end
      end
    end
    current_count = 6'd30; phase_63 = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_valid, o_sat, o_seq_err, o_filtered} !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_mid_async got {v,s,e,filt}=%h required 00000", {o_valid, o_sat, o_seq_err, o_filtered});
    end
    #1;
    rst = 1'b0;
    model_reset();
    gen_frame(1'b0);
    for (int k = 30; k < 130; k++) begin
      if (k < 64)       step(k, k == 63, xs[k], cs[k]);
      else if (k < 128) step(k - 64, (k - 64) == 63, xs[k - 64], cs[k - 64]);
      else              step(k - 128, 1'b0, 16'h0, 16'h0);
      if (have) begin
        n_checks++;
        if (obs !== expv) begin
          n_errors++;
          $display("FAIL reset_mid post step %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
        end
        if (obs[18]) nv++;
      end
    end
    n_checks++;
    if (nv != 1 || obs[18] !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_valids got %0d last_v=%b required 1 1", nv, obs[18]);
    end
    do_reset();
  endtask

  task automatic test_partial();
    int nv, ne;
    nv = 0; ne = 0;
    gen_frame(1'b0);
    for (int k = 40; k < 130; k++) begin
      if (k < 64)       step(k, k == 63, xs[k], cs[k]);
      else if (k < 128) step(k - 64, (k - 64) == 63, xs[k - 64], cs[k - 64]);
      else              step(k - 128, 1'b0, 16'h0, 16'h0);
      if (have) begin
        n_checks++;
        if (obs !== expv) begin
          n_errors++;
          $display("FAIL partial step %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
        end
        if (obs[18]) nv++;
        if (obs[16]) ne++;
      end
    end
    n_checks++;
    if (nv != 1 || ne != 0) begin
      n_errors++;
      $display("FAIL partial_counts got valids=%0d errs=%0d required 1 0", nv, ne);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    int last_v, nv;
    last_v = -1; nv = 0;
    for (int f = 0; f < 4; f++) begin
      gen_frame(f[0]);
      for (int k = 0; k < 64; k++) begin
        step(k, k == 63, xs[k], cs[k]);
        if (have) begin
          n_checks++;
          if (obs !== expv) begin
            n_errors++;
            $display("FAIL back_to_back frame %0d step %0d got {v,s,e,filt}=%h required %h", f, k, obs, expv);
          end
          if (obs[18]) begin
            nv++;
            if (last_v >= 0) begin
              n_checks++;
              if (f * 64 + k - last_v != 64) begin
                n_errors++;
                $display("FAIL valid_spacing got %0d required 64", f * 64 + k - last_v);
              end
            end
            last_v = f * 64 + k;
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(k, 1'b0, 16'h0, 16'h0);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL back_to_back flush %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
      end
    end
    n_checks++;
    if (nv != 3 || obs[18] !== 1'b1 || 256 + 1 - last_v != 64) begin
      n_errors++;
      $display("FAIL back_to_back_final got valids=%0d last_v=%b gap=%0d required 3 1 64", nv, obs[18], 257 - last_v);
    end
    do_reset();
  endtask

  task automatic test_random();
    int mode, fk, cnt;
    bit ph;
    for (int f = 0; f < 8; f++) begin
      mode = $urandom_range(0, 3);
      fk   = $urandom_range(1, 60);
      gen_frame(1'($urandom_range(0, 1)));
      for (int k = 0; k < 64; k++) begin
        cnt = k;
        ph  = (k == 63);
        if (mode == 1 && k == fk) cnt = k + 2;
        if (mode == 2 && k == fk) ph = 1'b1;
        if (mode == 3 && k == 63) ph = 1'b0;
        step(cnt, ph, xs[k], cs[k]);
        if (have) begin
          n_checks++;
          if (obs !== expv) begin
            n_errors++;
            $display("FAIL random frame %0d mode %0d step %0d got {v,s,e,filt}=%h required %h", f, mode, k, obs, expv);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(k, 1'b0, 16'h0, 16'h0);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL random flush %0d got {v,s,e,filt}=%h required %h", k, obs, expv);
      end
    end
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_seq_skip();
    test_phase_err();
    test_reset_mid();
    test_partial();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
